// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Produces packed BCD digits, a leading-zero mask and a saturation flag.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_WIDTH = 20,
    parameter int unsigned DIGITS    = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     bcd_out,
    output logic [DIGITS-1:0]       digit_valid,
    output logic                    overflow
);

    localparam int unsigned ACC_DIGITS = 10;
    localparam int unsigned ACC_W      = 4 * ACC_DIGITS;
    localparam int unsigned OUT_W      = 4 * DIGITS;
    localparam int unsigned CNT_W      = 6;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [BIN_WIDTH-1:0] shift_q, shift_d;
    logic [ACC_W-1:0]     acc_q,   acc_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;
    logic [OUT_W-1:0]     bcd_q,   bcd_d;
    logic [DIGITS-1:0]    valid_q, valid_d;
    logic                 ovf_q,   ovf_d;

    logic [ACC_W-1:0]     adj_c;
    logic                 hi_nz_c;
    logic [DIGITS-1:0]    exact_valid_c;
    logic                 any_nz_c;

    // Accumulator helpers: add-3 correction, upper-digit overflow and leading-zero mask
    always_comb begin
        adj_c         = acc_q;
        hi_nz_c       = |acc_q[ACC_W-1:OUT_W];
        exact_valid_c = '0;
        any_nz_c      = 1'b0;
        for (int i = 0; i < int'(ACC_DIGITS); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            any_nz_c         = any_nz_c | (acc_q[4*i +: 4] != 4'd0);
            exact_valid_c[i] = any_nz_c;
        end
        exact_valid_c[0] = 1'b1;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d = bin_in;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(BIN_WIDTH);
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d   = {adj_c[ACC_W-2:0], shift_q[BIN_WIDTH-1]};
                shift_d = shift_q << 1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (hi_nz_c) begin
                    ovf_d   = 1'b1;
                    bcd_d   = {DIGITS{4'h9}};
                    valid_d = '1;
                end else begin
                    ovf_d   = 1'b0;
                    bcd_d   = acc_q[OUT_W-1:0];
                    valid_d = exact_valid_c;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            valid_q <= DIGITS'(1);
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign bcd_out     = bcd_q;
    assign digit_valid = valid_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq with hand-computed expected results.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [19:0] bin_in;
    logic        busy;
    logic        done;
    logic [23:0] bcd_out;
    logic [5:0]  digit_valid;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [23:0] bcd;
        logic [5:0]  dv;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t sb[$];

    bin_to_bcd_seq #(.BIN_WIDTH(20), .DIGITS(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .bin_in      (bin_in),
        .busy        (busy),
        .done        (done),
        .bcd_out     (bcd_out),
        .digit_valid (digit_valid),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bcd_out",     32'(bcd_out),     32'(e.bcd));
                check("digit_valid", 32'(digit_valid), 32'(e.dv));
                check("overflow",    32'(overflow),    32'(e.ovf));
                check("latency",     32'(cyc - e.acc), 32'd21);
                check("busy_at_done", 32'(busy),       32'd0);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge
    task automatic issue(input logic [19:0] v, input logic [23:0] b, input logic [5:0] dv,
                         input logic o, input bit expect_res, output int acc);
        exp_t e;
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        acc   = cyc;
        start = 1'b0;
        if (expect_res) begin
            e.bcd = b; e.dv = dv; e.ovf = o; e.acc = acc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    int a;

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        check("rst_busy",  32'(busy),        32'd0);
        check("rst_done",  32'(done),        32'd0);
        check("rst_bcd",   32'(bcd_out),     32'h000000);
        check("rst_valid", 32'(digit_valid), 32'b000001);
        check("rst_ovf",   32'(overflow),    32'd0);

        // Directed conversions
        issue(20'd0, 24'h000000, 6'b000001, 1'b0, 1'b1, a);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_empty();
        issue(20'd12345,   24'h012345, 6'b011111, 1'b0, 1'b1, a); wait_empty();
        issue(20'd999999,  24'h999999, 6'b111111, 1'b0, 1'b1, a); wait_empty();
        issue(20'd1000000, 24'h999999, 6'b111111, 1'b1, 1'b1, a); wait_empty();
        issue(20'd1048575, 24'h999999, 6'b111111, 1'b1, 1'b1, a); wait_empty();
        issue(20'd100000,  24'h100000, 6'b111111, 1'b0, 1'b1, a); wait_empty();
        issue(20'd10,      24'h000010, 6'b000011, 1'b0, 1'b1, a); wait_empty();
        check("held_bcd", 32'(bcd_out), 32'h000010);

        // Start while busy is ignored; start in the done cycle is accepted
        issue(20'd7, 24'h000007, 6'b000001, 1'b0, 1'b1, a);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        bin_in = 20'd99;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100 && cyc != a + 21; k++) @(negedge clk);
        check("done_cycle_reached", 32'(cyc - a), 32'd21);
        issue(20'd42, 24'h000042, 6'b000011, 1'b0, 1'b1, a);
        wait_empty();

        // Reset mid-conversion aborts with no done pulse
        issue(20'd54321, 24'h0, 6'h0, 1'b0, 1'b0, a);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy",  32'(busy),        32'd0);
        check("abort_done",  32'(done),        32'd0);
        check("abort_bcd",   32'(bcd_out),     32'h000000);
        check("abort_valid", 32'(digit_valid), 32'b000001);
        check("abort_ovf",   32'(overflow),    32'd0);
        repeat (30) @(negedge clk);

        issue(20'd54321, 24'h054321, 6'b011111, 1'b0, 1'b1, a);
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Iterative double-dabble binary-to-BCD converter. Sits directly upstream of the per-digit seven-segment decoders that drive the HEX displays.
- Takes an unsigned binary value (frame counter, pattern index, etc.) and produces DIGITS packed 4-bit BCD nibbles, one per display.
- Also produces a leading-zero mask for display blanking and a saturation/overflow flag.
- One bit is converted per clock, so the block is small enough to replicate per status readout.

Parameters:
- BIN_WIDTH, 20, width of the binary input; legal range 1..32.
- DIGITS, 6, number of BCD digits output; legal range 1..8.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, request a conversion; sampled only in IDLE.
- bin_in, input, BIN_WIDTH, unsigned value; captured on the edge that accepts start.
- busy, output, 1, high while a conversion is in progress.
- done, output, 1, single-cycle pulse when results update.
- bcd_out, output, 4*DIGITS, packed BCD result; nibble i = 10^i digit (bits 4i+3:4i); held between conversions.
- digit_valid, output, DIGITS, bit i high if the digit is significant (not a leading zero).
- overflow, output, 1, value exceeded 10^DIGITS-1; held with bcd_out.

Behaviour:
- Reset values: state IDLE, busy=0, done=0, bcd_out=0, digit_valid=1 (bit 0 only), overflow=0. Internal shift/BCD registers are cleared.
- The reset has priority over everything and aborts any conversion. Outputs return to the reset values on the next edge, with no done pulse.
- States: IDLE, SHIFT, FINISH.
- IDLE, start=1 at edge E0:
  - Latch bin_in into the shift register.
  - Clear the internal BCD accumulator.
  - Load the bit counter with BIN_WIDTH.
  - Go to SHIFT; busy=1 after E0.
- SHIFT, one iteration per edge E1..E_BIN_WIDTH:
  - For every accumulator digit >= 5, add 3 (4-bit add, no carry out of the nibble).
  - Then shift {accumulator, shift reg} left 1 bit, MSB of bin first.
  - Decrement the counter. After the final shift, go to FINISH.
- Internal accumulator width: 10 digits (enough for 2^32-1). Only the low DIGITS digits are exported.
- FINISH, edge E_(BIN_WIDTH+1):
  - Register bcd_out, digit_valid and overflow.
  - done=1 for exactly this one following cycle.
  - busy=0; go to IDLE.
- Latency: done is visible BIN_WIDTH+1 cycles after the accepting edge; 21 cycles at default. busy is high for exactly BIN_WIDTH+1 cycles.
- start while busy (SHIFT/FINISH) is ignored. No queuing, and the latched bin_in is unaffected.
- start is accepted in the cycle where done=1, since the state is already IDLE. Back-to-back throughput is one result per BIN_WIDTH+2 cycles.
- A held-high start restarts a conversion at every IDLE edge. This is legal; bcd_out changes only at each done.
- Overflow applies when any accumulator digit at index >= DIGITS is nonzero:
  - overflow=1.
  - bcd_out is forced to all nibbles 9.
  - digit_valid is all ones.
- Otherwise overflow=0 and bcd_out is the exact conversion.
- digit_valid[0] is always 1. For i>0, digit_valid[i]=1 if and only if any exported digit j>=i is nonzero.
- bcd_out, digit_valid and overflow change only on the done edge or on reset. They are never partially updated mid-conversion, so the downstream decoders see no glitches.
- Every nibble of bcd_out is in 0..9 at all times.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, bcd_out=0x000000, digit_valid=6'b000001, overflow=0.
- start with bin_in=0 -> done high exactly 21 cycles after the accepting edge; bcd_out=0x000000, digit_valid=6'b000001.
- bin_in=12345 -> bcd_out=0x012345, digit_valid=6'b011111, overflow=0.
- bin_in=999999 -> bcd_out=0x999999, digit_valid=6'b111111, overflow=0.
- bin_in=1000000 -> overflow=1, bcd_out=0x999999, digit_valid=6'b111111.
- bin_in=1048575 -> overflow=1, bcd_out=0x999999, digit_valid=6'b111111.
- Start 7 (bcd 0x000007, valid 6'b000001); pulse start with bin_in=99 at cycle 5 of busy -> ignored, result 0x000007.
- Then start 42 in the done cycle -> accepted; next done gives 0x000042, valid 6'b000011.
- Assert reset at cycle 10 of a conversion of 54321 -> next edge busy=0, bcd_out=0, no done pulse.
- A fresh start with 54321 afterwards -> 0x054321 after 21 cycles.
